// File: rtl/sent_cfg_dispatch.sv
// sent_cfg_dispatch
// Parses SENT parameter frames from the UDP receive AXI-Stream and validates
// each frame. Accepted parameters go into a per-channel shadow set. The shadow
// set is copied to the active set only while that channel's transmitter is
// between frames.
//
// Ports:
//   clk, rst            module clock, synchronous active-high reset
//   rx_axis_udp_*       32-bit payload beats (no back-pressure)
//   ch_busy             per-channel transmitter mid-frame indication
//   cfg_valid           channel has had at least one config applied
//   cfg_update          one-cycle pulse when a channel's active config changes
//   cfg_*               flattened active config, channel ch at [ch*W +: W]
//   err_cnt             saturating count of rejected frames
module sent_cfg_dispatch #(
  parameter int unsigned SENT_NUM      = 5,
  parameter int unsigned ID_SENT_PARAM = 2,
  parameter int unsigned CLK_FREQ      = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           rx_axis_udp_tdata,
  input  logic                  rx_axis_udp_tvalid,
  input  logic                  rx_axis_udp_tlast,
  input  logic [SENT_NUM-1:0]   ch_busy,
  output logic [SENT_NUM-1:0]   cfg_valid,
  output logic [SENT_NUM-1:0]   cfg_update,
  output logic [16*SENT_NUM-1:0] cfg_tick_div,
  output logic [8*SENT_NUM-1:0] cfg_ltick_len,
  output logic [2*SENT_NUM-1:0] cfg_pause_mode,
  output logic [16*SENT_NUM-1:0] cfg_pause_len,
  output logic [SENT_NUM-1:0]   cfg_crc_mode,
  output logic [4*SENT_NUM-1:0] cfg_status_nibble,
  output logic [3*SENT_NUM-1:0] cfg_data_len,
  output logic [24*SENT_NUM-1:0] cfg_data_nibble,
  output logic [15:0]           err_cnt
);

  localparam int unsigned TICKS_PER_US = CLK_FREQ / 1000000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_W1    = 3'd1;
  localparam logic [2:0] ST_W2    = 3'd2;
  localparam logic [2:0] ST_W3    = 3'd3;
  localparam logic [2:0] ST_DROP  = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;

  logic [2:0]  state_q, state_d;

  // Captured frame fields
  logic [7:0]  ch_q;
  logic [7:0]  ctick_q;
  logic [7:0]  ltick_q;
  logic [1:0]  pmode_q;
  logic [15:0] plen_q;
  logic        crc_q;
  logic [3:0]  status_q;
  logic [2:0]  dlen_q;
  logic [23:0] data_q;

  logic        cap_w0_c, cap_w1_c, cap_w2_c, cap_w3_c;
  logic [1:0]  err_add_c;
  logic        commit_ok_c;
  logic        fields_ok_c;
  logic        id_match_c;
  logic        idle_eval_c;
  logic [15:0] err_cnt_d;
  logic [16:0] err_sum_c;
  logic [15:0] tick_div_c;

  logic [SENT_NUM-1:0] pending_q, pending_d;
  logic [SENT_NUM-1:0] commit_c, apply_c;

  // Shadow parameter sets
  logic [16*SENT_NUM-1:0] sh_tick_div_q;
  logic [8*SENT_NUM-1:0]  sh_ltick_q;
  logic [2*SENT_NUM-1:0]  sh_pmode_q;
  logic [16*SENT_NUM-1:0] sh_plen_q;
  logic [SENT_NUM-1:0]    sh_crc_q;
  logic [4*SENT_NUM-1:0]  sh_status_q;
  logic [3*SENT_NUM-1:0]  sh_dlen_q;
  logic [24*SENT_NUM-1:0] sh_data_q;

  assign id_match_c = (rx_axis_udp_tdata[31:16] == 16'(ID_SENT_PARAM));

  // Field validation, consumed only in CHECK
  always_comb begin
    fields_ok_c = (ch_q < 8'(SENT_NUM))
               && (ctick_q >= 8'd3) && (ctick_q <= 8'd90)
               && (ltick_q >= 8'd4)
               && (pmode_q != 2'd3)
               && ((pmode_q == 2'd0) || ((plen_q >= 16'd12) && (plen_q <= 16'd768)))
               && (dlen_q >= 3'd1) && (dlen_q <= 3'd6);
  end

  assign tick_div_c = 16'(32'(ctick_q) * TICKS_PER_US);

  // Parser next-state; CHECK also runs the IDLE decode so a back-to-back W0 is kept
  always_comb begin
    state_d     = state_q;
    cap_w0_c    = 1'b0;
    cap_w1_c    = 1'b0;
    cap_w2_c    = 1'b0;
    cap_w3_c    = 1'b0;
    err_add_c   = 2'd0;
    commit_ok_c = 1'b0;
    idle_eval_c = 1'b0;

    case (state_q)
      ST_IDLE: idle_eval_c = 1'b1;
      ST_CHECK: begin
        state_d     = ST_IDLE;
        idle_eval_c = 1'b1;
        if (fields_ok_c) commit_ok_c = 1'b1;
        else             err_add_c   = 2'd1;
      end
      ST_W1: if (rx_axis_udp_tvalid) begin
        cap_w1_c = 1'b1;
        if (rx_axis_udp_tlast) begin
          err_add_c = 2'd1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_W2;
        end
      end
      ST_W2: if (rx_axis_udp_tvalid) begin
        cap_w2_c = 1'b1;
        if (rx_axis_udp_tlast) begin
          err_add_c = 2'd1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_W3;
        end
      end
      ST_W3: if (rx_axis_udp_tvalid) begin
        cap_w3_c = 1'b1;
        if (rx_axis_udp_tlast) begin
          state_d = ST_CHECK;
        end else begin
          err_add_c = 2'd1;
          state_d   = ST_DROP;
        end
      end
      ST_DROP: if (rx_axis_udp_tvalid && rx_axis_udp_tlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (idle_eval_c && rx_axis_udp_tvalid) begin
      if (id_match_c) begin
        cap_w0_c = 1'b1;
        if (rx_axis_udp_tlast) begin
          err_add_c = err_add_c + 2'd1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_W1;
        end
      end else begin
        state_d = rx_axis_udp_tlast ? ST_IDLE : ST_DROP;
      end
    end
  end

  // Saturating error counter
  always_comb begin
    err_sum_c = 17'(err_cnt) + 17'(err_add_c);
    err_cnt_d = err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
  end

  // Commit/apply per channel; a same-cycle commit defers the apply
  always_comb begin
    commit_c = '0;
    apply_c  = '0;
    for (int ch = 0; ch < SENT_NUM; ch++) begin
      commit_c[ch] = commit_ok_c && (ch_q == 8'(ch));
      apply_c[ch]  = pending_q[ch] && !ch_busy[ch] && !commit_c[ch];
    end
    pending_d = (pending_q & ~apply_c) | commit_c;
  end

  // Parser state, captured fields, error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      ctick_q  <= '0;
      ltick_q  <= '0;
      pmode_q  <= '0;
      plen_q   <= '0;
      crc_q    <= 1'b0;
      status_q <= '0;
      dlen_q   <= '0;
      data_q   <= '0;
      err_cnt  <= '0;
    end else begin
      state_q <= state_d;
      err_cnt <= err_cnt_d;
      if (cap_w0_c) ch_q <= rx_axis_udp_tdata[15:8];
      if (cap_w1_c) begin
        ctick_q      <= rx_axis_udp_tdata[31:24];
        ltick_q      <= rx_axis_udp_tdata[23:16];
        pmode_q      <= rx_axis_udp_tdata[9:8];
        plen_q[15:8] <= rx_axis_udp_tdata[7:0];
      end
      if (cap_w2_c) begin
        plen_q[7:0] <= rx_axis_udp_tdata[31:24];
        crc_q       <= rx_axis_udp_tdata[16];
        status_q    <= rx_axis_udp_tdata[11:8];
        dlen_q      <= rx_axis_udp_tdata[2:0];
      end
      if (cap_w3_c) data_q <= rx_axis_udp_tdata[31:8];
    end
  end

  // Shadow and active configuration sets
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q         <= '0;
      cfg_valid         <= '0;
      cfg_update        <= '0;
      sh_tick_div_q     <= '0;
      sh_ltick_q        <= '0;
      sh_pmode_q        <= '0;
      sh_plen_q         <= '0;
      sh_crc_q          <= '0;
      sh_status_q       <= '0;
      sh_dlen_q         <= '0;
      sh_data_q         <= '0;
      cfg_tick_div      <= '0;
      cfg_ltick_len     <= '0;
      cfg_pause_mode    <= '0;
      cfg_pause_len     <= '0;
      cfg_crc_mode      <= '0;
      cfg_status_nibble <= '0;
      cfg_data_len      <= '0;
      cfg_data_nibble   <= '0;
    end else begin
      pending_q  <= pending_d;
      cfg_update <= apply_c;
      cfg_valid  <= cfg_valid | apply_c;
      for (int ch = 0; ch < SENT_NUM; ch++) begin
        if (commit_c[ch]) begin
          sh_tick_div_q[ch*16 +: 16] <= tick_div_c;
          sh_ltick_q[ch*8 +: 8]      <= ltick_q;
          sh_pmode_q[ch*2 +: 2]      <= pmode_q;
          sh_plen_q[ch*16 +: 16]     <= plen_q;
          sh_crc_q[ch]               <= crc_q;
          sh_status_q[ch*4 +: 4]     <= status_q;
          sh_dlen_q[ch*3 +: 3]       <= dlen_q;
          sh_data_q[ch*24 +: 24]     <= data_q;
        end
        if (apply_c[ch]) begin
          cfg_tick_div[ch*16 +: 16]    <= sh_tick_div_q[ch*16 +: 16];
          cfg_ltick_len[ch*8 +: 8]     <= sh_ltick_q[ch*8 +: 8];
          cfg_pause_mode[ch*2 +: 2]    <= sh_pmode_q[ch*2 +: 2];
          cfg_pause_len[ch*16 +: 16]   <= sh_plen_q[ch*16 +: 16];
          cfg_crc_mode[ch]             <= sh_crc_q[ch];
          cfg_status_nibble[ch*4 +: 4] <= sh_status_q[ch*4 +: 4];
          cfg_data_len[ch*3 +: 3]      <= sh_dlen_q[ch*3 +: 3];
          cfg_data_nibble[ch*24 +: 24] <= sh_data_q[ch*24 +: 24];
        end
      end
    end
  end

endmodule

// File: tb/tb_sent_cfg_dispatch.sv
// Directed bench for sent_cfg_dispatch: frame parsing, validation, busy
// deferral, error counting, back-to-back frames and reset.
module tb_sent_cfg_dispatch;

  localparam int unsigned N = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    tdata;
  logic           tvalid;
  logic           tlast;
  logic [N-1:0]   ch_busy;
  logic [N-1:0]   cfg_valid;
  logic [N-1:0]   cfg_update;
  logic [16*N-1:0] cfg_tick_div;
  logic [8*N-1:0] cfg_ltick_len;
  logic [2*N-1:0] cfg_pause_mode;
  logic [16*N-1:0] cfg_pause_len;
  logic [N-1:0]   cfg_crc_mode;
  logic [4*N-1:0] cfg_status_nibble;
  logic [3*N-1:0] cfg_data_len;
  logic [24*N-1:0] cfg_data_nibble;
  logic [15:0]    err_cnt;

  sent_cfg_dispatch #(.SENT_NUM(N), .ID_SENT_PARAM(2), .CLK_FREQ(100000000)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_axis_udp_tdata (tdata),
    .rx_axis_udp_tvalid(tvalid),
    .rx_axis_udp_tlast (tlast),
    .ch_busy           (ch_busy),
    .cfg_valid         (cfg_valid),
    .cfg_update        (cfg_update),
    .cfg_tick_div      (cfg_tick_div),
    .cfg_ltick_len     (cfg_ltick_len),
    .cfg_pause_mode    (cfg_pause_mode),
    .cfg_pause_len     (cfg_pause_len),
    .cfg_crc_mode      (cfg_crc_mode),
    .cfg_status_nibble (cfg_status_nibble),
    .cfg_data_len      (cfg_data_len),
    .cfg_data_nibble   (cfg_data_nibble),
    .err_cnt           (err_cnt)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc_cnt = 0;
  int upd_cnt [N];
  int upd_cyc [N];
  logic [31:0] fw0, fw1, fw2, fw3;

  // Observe update pulses mid-cycle, away from both clock edges
  always @(posedge clk) begin
    #2;
    cyc_cnt++;
    for (int c = 0; c < N; c++) begin
      if (cfg_update[c]) begin
        upd_cnt[c]++;
        upd_cyc[c] = cyc_cnt;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [15:0] id, input logic [7:0] ch, input logic [7:0] ctick,
                       input logic [7:0] ltick, input logic [1:0] pm, input logic [15:0] plen,
                       input logic crc, input logic [3:0] st, input logic [2:0] dl,
                       input logic [23:0] data);
    fw0 = {id, ch, 8'h00};
    fw1 = {ctick, ltick, 6'h00, pm, plen[15:8]};
    fw2 = {plen[7:0], 7'h00, crc, 4'h0, st, 5'h00, dl};
    fw3 = {data, 8'h00};
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    @(negedge clk);
    tdata = d; tvalid = 1'b1; tlast = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    end
  endtask

  task automatic send_built;
    beat(fw0, 1'b0); beat(fw1, 1'b0); beat(fw2, 1'b0); beat(fw3, 1'b1);
  endtask

  task automatic clear_counts;
    for (int c = 0; c < N; c++) begin
      upd_cnt[c] = 0;
      upd_cyc[c] = 0;
    end
  endtask

  initial begin
    rst = 1'b1; tdata = '0; tvalid = 1'b0; tlast = 1'b0; ch_busy = '0;
    clear_counts();
    idle(3);
    chk("rst_valid", 128'(cfg_valid), 128'(0));
    chk("rst_update", 128'(cfg_update), 128'(0));
    chk("rst_err", 128'(err_cnt), 128'(0));
    chk("rst_data", 128'(cfg_data_nibble), 128'(0));
    @(negedge clk); rst = 1'b0;
    idle(1);
    clear_counts();

    // Channel 0 basic frame, latency check
    build(16'd2, 8'd0, 8'd3, 8'd4, 2'd0, 16'd10, 1'b0, 4'hA, 3'd6, 24'h123456);
    send_built();
    idle(1);
    chk("t1_upd_c1", 128'(cfg_update), 128'(0));
    idle(1);
    chk("t1_upd_c2_early", 128'(cfg_update), 128'(0));
    idle(1);
    chk("t1_upd_pulse", 128'(cfg_update), 128'(5'b00001));
    chk("t1_tickdiv", 128'(cfg_tick_div[15:0]), 128'(300));
    chk("t1_ltick", 128'(cfg_ltick_len[7:0]), 128'(4));
    chk("t1_status", 128'(cfg_status_nibble[3:0]), 128'(4'hA));
    chk("t1_data", 128'(cfg_data_nibble[23:0]), 128'(24'h123456));
    chk("t1_dlen", 128'(cfg_data_len[2:0]), 128'(6));
    chk("t1_plen", 128'(cfg_pause_len[15:0]), 128'(10));
    chk("t1_pmode", 128'(cfg_pause_mode[1:0]), 128'(0));
    chk("t1_crc", 128'(cfg_crc_mode[0]), 128'(0));
    chk("t1_valid", 128'(cfg_valid), 128'(5'b00001));
    chk("t1_err", 128'(err_cnt), 128'(0));
    idle(1);
    chk("t1_upd_single", 128'(cfg_update), 128'(0));

    // Busy channel: two frames queue up, latest wins on release
    clear_counts();
    @(negedge clk); ch_busy = 5'b00001; tvalid = 1'b0;
    build(16'd2, 8'd0, 8'd3, 8'd4, 2'd0, 16'd10, 1'b0, 4'hA, 3'd6, 24'h123456);
    send_built();
    build(16'd2, 8'd0, 8'd3, 8'd4, 2'd0, 16'd10, 1'b0, 4'hA, 3'd6, 24'hABCDEF);
    send_built();
    idle(41);
    chk("t2_no_upd_busy", 128'(upd_cnt[0]), 128'(0));
    chk("t2_data_hold", 128'(cfg_data_nibble[23:0]), 128'(24'h123456));
    @(negedge clk); ch_busy = '0;
    idle(4);
    chk("t2_one_upd", 128'(upd_cnt[0]), 128'(1));
    chk("t2_data_new", 128'(cfg_data_nibble[23:0]), 128'(24'hABCDEF));
    chk("t2_err", 128'(err_cnt), 128'(0));

    // Invalid field frames
    clear_counts();
    build(16'd2, 8'd0, 8'd91, 8'd4, 2'd0, 16'd10, 1'b0, 4'h1, 3'd6, 24'h111111);
    send_built(); idle(4);
    chk("t3_ctick91_err", 128'(err_cnt), 128'(1));
    build(16'd2, 8'd5, 8'd3, 8'd4, 2'd0, 16'd10, 1'b0, 4'h1, 3'd6, 24'h222222);
    send_built(); idle(4);
    chk("t3_ch5_err", 128'(err_cnt), 128'(2));
    build(16'd2, 8'd0, 8'd3, 8'd4, 2'd0, 16'd10, 1'b0, 4'h1, 3'd0, 24'h333333);
    send_built(); idle(4);
    chk("t3_dlen0_err", 128'(err_cnt), 128'(3));
    build(16'd2, 8'd0, 8'd3, 8'd4, 2'd1, 16'd11, 1'b0, 4'h1, 3'd6, 24'h444444);
    send_built(); idle(4);
    chk("t3_plen11_err", 128'(err_cnt), 128'(4));
    chk("t3_no_upd", 128'(upd_cnt[0]), 128'(0));
    chk("t3_data_kept", 128'(cfg_data_nibble[23:0]), 128'(24'hABCDEF));

    // Short frame then a valid one
    build(16'd2, 8'd2, 8'd6, 8'd5, 2'd0, 16'd0, 1'b1, 4'h3, 3'd3, 24'h654321);
    beat(fw0, 1'b0); beat(fw1, 1'b0); beat(fw2, 1'b1);
    idle(3);
    chk("t4_short_err", 128'(err_cnt), 128'(5));
    send_built(); idle(4);
    chk("t4_after_short_upd", 128'(upd_cnt[2]), 128'(1));
    chk("t4_ch2_data", 128'(cfg_data_nibble[48 +: 24]), 128'(24'h654321));
    chk("t4_ch2_tick", 128'(cfg_tick_div[32 +: 16]), 128'(600));
    chk("t4_ch2_crc", 128'(cfg_crc_mode[2]), 128'(1));
    chk("t4_err_same", 128'(err_cnt), 128'(5));
    // Long frame: fifth beat looks like a short W0 and must be dropped
    build(16'd2, 8'd2, 8'd6, 8'd5, 2'd0, 16'd0, 1'b1, 4'h3, 3'd3, 24'h777777);
    beat(fw0, 1'b0); beat(fw1, 1'b0); beat(fw2, 1'b0); beat(fw3, 1'b0); beat(fw0, 1'b1);
    idle(4);
    chk("t4_long_err", 128'(err_cnt), 128'(6));
    chk("t4_long_no_upd", 128'(upd_cnt[2]), 128'(1));
    // Foreign ID frame ignored
    build(16'd3, 8'd2, 8'd6, 8'd5, 2'd0, 16'd0, 1'b1, 4'h3, 3'd3, 24'h888888);
    send_built(); idle(4);
    chk("t4_foreign_err", 128'(err_cnt), 128'(6));
    chk("t4_foreign_no_upd", 128'(upd_cnt[2]), 128'(1));
    chk("t4_ch2_unchanged", 128'(cfg_data_nibble[48 +: 24]), 128'(24'h654321));

    // Back-to-back frames, channel 1 then 4
    clear_counts();
    build(16'd2, 8'd1, 8'd10, 8'd4, 2'd1, 16'd12, 1'b1, 4'h5, 3'd1, 24'hC00000);
    send_built();
    build(16'd2, 8'd4, 8'd90, 8'd9, 2'd2, 16'd768, 1'b0, 4'hF, 3'd4, 24'hDEAD00);
    send_built();
    idle(6);
    chk("t5_upd1", 128'(upd_cnt[1]), 128'(1));
    chk("t5_upd4", 128'(upd_cnt[4]), 128'(1));
    chk("t5_spacing", 128'(upd_cyc[4] - upd_cyc[1]), 128'(4));
    chk("t5_ch1_tick", 128'(cfg_tick_div[16 +: 16]), 128'(1000));
    chk("t5_ch1_pmode", 128'(cfg_pause_mode[2 +: 2]), 128'(1));
    chk("t5_ch1_plen", 128'(cfg_pause_len[16 +: 16]), 128'(12));
    chk("t5_ch4_tick", 128'(cfg_tick_div[64 +: 16]), 128'(9000));
    chk("t5_ch4_plen", 128'(cfg_pause_len[64 +: 16]), 128'(768));
    chk("t5_ch4_status", 128'(cfg_status_nibble[16 +: 4]), 128'(4'hF));
    chk("t5_ch4_data", 128'(cfg_data_nibble[96 +: 24]), 128'(24'hDEAD00));
    chk("t5_valid", 128'(cfg_valid), 128'(5'b10111));
    chk("t5_err", 128'(err_cnt), 128'(6));

    // Reset in the middle of a frame
    build(16'd2, 8'd3, 8'd5, 8'd4, 2'd0, 16'd0, 1'b0, 4'h7, 3'd2, 24'h5A5A5A);
    beat(fw0, 1'b0); beat(fw1, 1'b0);
    @(negedge clk); rst = 1'b1; tvalid = 1'b0; tlast = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 128'(cfg_valid), 128'(0));
    chk("t6_rst_err", 128'(err_cnt), 128'(0));
    chk("t6_rst_tick", 128'(cfg_tick_div), 128'(0));
    chk("t6_rst_data", 128'(cfg_data_nibble), 128'(0));
    chk("t6_rst_upd", 128'(cfg_update), 128'(0));
    rst = 1'b0;
    clear_counts();
    send_built(); idle(4);
    chk("t6_post_upd", 128'(upd_cnt[3]), 128'(1));
    chk("t6_post_valid", 128'(cfg_valid), 128'(5'b01000));
    chk("t6_post_tick", 128'(cfg_tick_div[48 +: 16]), 128'(500));
    chk("t6_post_data", 128'(cfg_data_nibble[72 +: 24]), 128'(24'h5A5A5A));
    chk("t6_post_err", 128'(err_cnt), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sent_cfg_dispatch.md
Name: sent_cfg_dispatch

Overview:
Parses SENT parameter frames from the user UDP AXI-Stream receive interface and validates each frame. Holds a shadow parameter set per channel and hands it to each SENT channel transmitter only when that channel is between frames. It sits between the UDP receive path and the SENT_NUM channel transmitters inside sent_top, and is the sole writer of channel configuration.

Parameters:
SENT_NUM, 5, number of SENT channels (1..16)
ID_SENT_PARAM, 2, frame ID in word0[31:16] that selects a SENT parameter frame
CLK_FREQ, 100000000, module clock frequency in Hz; used for the tick divisor

Ports:
clk  in  1  module clock
rst  in  1  synchronous active-high reset
rx_axis_udp_tdata  in  32  UDP payload word
rx_axis_udp_tvalid  in  1  beat valid; there is no tready, so every valid beat is consumed
rx_axis_udp_tlast  in  1  last beat of a UDP frame
ch_busy  in  SENT_NUM  per-channel transmitter is mid-frame; config must not change while high
cfg_valid  out  SENT_NUM  channel has received at least one applied config
cfg_update  out  SENT_NUM  one-cycle pulse when a channel's active config changes
cfg_tick_div  out  16*SENT_NUM  clocks per tick = ctick_len*(CLK_FREQ/1000000)
cfg_ltick_len  out  8*SENT_NUM  low-pulse ticks
cfg_pause_mode  out  2*SENT_NUM  0 none, 1 fixed, 2 variable
cfg_pause_len  out  16*SENT_NUM  pause length in ticks
cfg_crc_mode  out  SENT_NUM  0 legacy, 1 recommended
cfg_status_nibble  out  4*SENT_NUM  status/communication nibble
cfg_data_len  out  3*SENT_NUM  data nibbles (1..6)
cfg_data_nibble  out  24*SENT_NUM  {nibble1..nibble6}
err_cnt  out  16  count of rejected frames, saturating at 16'hFFFF

Behaviour:
- Channel ch occupies slice [ch*W +: W] of every flattened bus.
- Frame layout, one word per valid beat:
  - W0 = {id[15:0], channel[7:0], 8'h0}
  - W1 = {ctick[7:0], ltick[7:0], 6'h0, pause_mode[1:0], pause_len[15:8]}
  - W2 = {pause_len[7:0], 7'h0, crc, 4'h0, status[3:0], 5'h0, data_len[2:0]}
  - W3 = {data[23:0], 8'h0}; tlast must be set on W3.
- Parser FSM, advancing only on valid beats:
  - IDLE: if id != ID_SENT_PARAM, go to DROP, or stay in IDLE if tlast is set on the same beat.
  - Otherwise capture the channel and go to W1, then W2, then W3.
  - tlast on W0, W1 or W2: frame is short; count an error and return to IDLE.
  - W3 without tlast: frame is long; count an error and go to DROP.
  - W3 with tlast: go to CHECK.
  - DROP: wait for a tlast beat, then go to IDLE. A foreign-ID frame does not count as an error.
  - CHECK (one cycle, no beat consumed): validate the captured fields, then return to IDLE.
- CHECK validation: channel < SENT_NUM; 3 <= ctick <= 90; ltick >= 4; pause_mode != 3; 12 <= pause_len <= 768 when pause_mode != 0; 1 <= data_len <= 6.
  - Pass: write the channel's shadow registers (tick_div computed here) and set pending[ch].
  - Fail: err_cnt += 1, nothing written.
- The beat following the W3 beat may arrive while the FSM is in CHECK; that beat is treated as W0 of a new frame. CHECK must evaluate IDLE logic on the same cycle, so no beat is lost.
- Apply: in any cycle where pending[ch] = 1 and ch_busy[ch] = 0, copy shadow to active, clear pending, pulse cfg_update[ch], and set cfg_valid[ch].
  - Latency: with ch_busy low, cfg_update and the new outputs appear 2 cycles after the W3 beat is sampled.
- A commit to a channel that is already pending overwrites its shadow (latest wins) and leaves pending set.
- If a commit and an apply coincide on the same channel, the apply is suppressed that cycle and occurs the next eligible cycle with the new values.
- Channels are independent; several channels may apply in the same cycle.
- Reset: FSM goes to IDLE. All pending bits, cfg_valid, cfg_update, all cfg_* active and shadow registers, and err_cnt are cleared to 0. Any partial frame is discarded. Beats after reset are parsed from W0.

Test Plan:
- Channel 0 frame (ctick 3, ltick 4, pause none, pause_len 10, legacy CRC, status 4'hA, data_len 6, data 24'h123456), ch_busy = 0 -> cfg_update[0] pulses 2 cycles after W3. Channel 0 outputs: tick_div = 300, ltick 4, status A, data 123456, cfg_valid[0] = 1. err_cnt = 0.
- Same frame with ch_busy[0] held high for 50 cycles -> no update while busy; a second frame with data 24'hABCDEF arrives meanwhile. On release, a single cfg_update[0] pulse with data ABCDEF.
- Invalid frames: ctick = 91; then channel = 5; then data_len = 0; then pause_mode 1 with pause_len 11 -> no cfg_update, err_cnt = 4.
- Malformed frames: tlast on W2 -> err_cnt += 1, the next valid frame is accepted. A 5-beat frame -> err_cnt += 1 and the fifth beat is dropped. A foreign-ID (3) 4-beat frame -> ignored, err_cnt unchanged.
- Back-to-back frames with no gap, for channels 1 then 4 -> both apply. cfg_update[1] precedes cfg_update[4] by 4 cycles.
- rst asserted after W1 of a frame -> all outputs 0. The next full valid frame is applied normally.
